cyc_ctrl: RTL and testbench
===========================

CYC_CTRL -- requirements
Module: cyc_ctrl

Interface
REQ-001 DATASIZE, 8, data width used for the cycle-info fields; IENBSIZE, 6, width of ienb; INSTSIZE, 17, width of chk_i.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 chk_i  input  17  decoded instruction info: [0] GO6, [2] HLT, [3] DIO, [7:4] extra-cycle mask, [11:8] write mask, [15:12] data-pointer mask, [16] condition (unused this revision).
REQ-005 ready  input  1  external memory/IO ready.
REQ-006 ienb  output  6  datapath enables: [0] RRD, [1] RWR, [2] COD, [3] DAT, [4] PC_, [5] PD_.
REQ-007 ale  output  1  address latch enable.
REQ-008 rd_  output  1  active-low read strobe.
REQ-009 wr_  output  1  active-low write strobe.
REQ-010 io_m  output  1  1 = IO cycle.
REQ-011 halt  output  1  halt acknowledge.
REQ-012 mcyc  output  3  current machine cycle, 1..5.
REQ-013 tst  output  3  current T-state: 1..6; 7 = TW.

Function
REQ-014 FSM states: T1, T2, TW, T3, T4, T5, T6, HALT; each state lasts one clk.
REQ-015 M1 (opcode fetch): T1 ale=1; T2 rd_=0; T3 rd_=0, COD=1, PC_=1; then T4.
REQ-016 At end of T4, chk_i[15:4] and chk_i[3:0] SHALL be latched; T4 drives RRD=1, and also RWR=1 when the mask is 0000 and HLT=0.
REQ-017 T4 SHALL go to T5 if GO6=1 (T5→T6→next), else to the next cycle.
REQ-018 Next cycle: lowest set mask bit n gives M(n+2) at T1; an empty mask gives M1 T1 with mcyc=1.
REQ-019 Mn T1: ale=1; PD_=latched cd[n-2]; io_m=DIO on M3, else 0.
REQ-020 Read Mn: T2 rd_=0; T3 rd_=0, DAT=1; PC_=1 if cd bit is 0; RWR=1 if this is the last pending cycle.
REQ-021 Write Mn: T2 and T3 wr_=0, RRD=1; T2 and T3 keep PD_ at its T1 value.
REQ-022 T2→TW when ready=0; TW holds strobes and PD_/io_m, repeating until ready=1, then T3.
REQ-023 HLT=1: after the last pending cycle, enter HALT; halt=1, strobes high, ienb=0; leave HALT only on rst.
REQ-024 Mask 1111 runs M2..M5 in order; mcyc SHALL never exceed 5.
REQ-025 ale, rd_, wr_, io_m and ienb SHALL be registered outputs, glitch-free, with no combinational input→output path.

Reset
REQ-026 rst SHALL win over every state, including TW and HALT.
REQ-027 Post-reset values: state=T1, mcyc=1, tst=1, ienb=0, ale=0, rd_=1, wr_=1, io_m=0, halt=0, latched masks=0.
REQ-028 The first cycle after rst release SHALL be M1 T1 with ale=1.

Configuration
REQ-029 Macro CYC_CTRL_WAIT_EN defined: TW SHALL be inserted as in REQ-022.
REQ-030 Macro CYC_CTRL_WAIT_EN undefined: ready SHALL be ignored, T2 always goes to T3, and TW is unreachable.

Structure
REQ-031 A shared include SHALL hold the ienb bit indices, chk_i field indices, and the T-state encodings (T1..T6=1..6, TW=7, HALT=0).
REQ-032 One sub-module, cyc_pick, SHALL be used: a combinational lowest-set-bit picker returning the next cycle number and a last-cycle flag.

Verification
REQ-033 mov r,r (mask 0000, GO6=0), ready=1: tst 1,2,3,4,1; RRD and RWR both 1 in T4; 4 clocks per instruction.
REQ-034 inx (GO6=1): tst 1,2,3,4,5,6,1; exactly one PC_ pulse.
REQ-035 mov m,r (mask 0001, wr 0001, cd 0001): M2 shows ale at T1; wr_=0, RRD=1, PD_=1 in T2 and T3; no DAT.
REQ-036 With CYC_CTRL_WAIT_EN and ready=0 for 3 clocks in M1 T2: tst sequence 1,2,7,7,7,3; rd_=0 throughout.
REQ-037 hlt (mask 0001, HLT=1): M2 read completes, then halt=1 and stays 1 for 20 clocks; rst pulse gives M1 T1.
REQ-038 rst asserted in M4 TW: next clk has state=T1, mcyc=1, all outputs at REQ-027 values.

Source files
------------

// File: rtl/cyc_ctrl_pkg.sv
// cyc_ctrl shared definitions: ienb bit indices, chk_i field indices,
// T-state encodings and the machine-cycle to mask-bit helper.
package cyc_ctrl_pkg;

  localparam int DATASIZE = 8;
  localparam int IENBSIZE = 6;
  localparam int INSTSIZE = 17;

  localparam int EN_RRD = 0;
  localparam int EN_RWR = 1;
  localparam int EN_COD = 2;
  localparam int EN_DAT = 3;
  localparam int EN_PC  = 4;
  localparam int EN_PD  = 5;

  localparam int CK_GO6  = 0;
  localparam int CK_HLT  = 2;
  localparam int CK_DIO  = 3;
  localparam int CK_EX   = 4;
  localparam int CK_WR   = 8;
  localparam int CK_CD   = 12;
  localparam int CK_COND = 16;

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_T1   = 3'd1,
    S_T2   = 3'd2,
    S_T3   = 3'd3,
    S_T4   = 3'd4,
    S_T5   = 3'd5,
    S_T6   = 3'd6,
    S_TW   = 3'd7
  } tstate_t;

  function automatic logic [3:0] cyc_bit(
    input logic [2:0] m
  );
    case (m)
      3'd2:    return 4'b0001;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0100;
      3'd5:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/cyc_ctrl_pick.sv
// cyc_pick: lowest-set-bit picker over the pending extra-cycle mask,
// giving the next machine cycle number and whether it is the last one.
module cyc_pick
  import cyc_ctrl_pkg::*;
(
  input  logic [3:0] mask,
  output logic [2:0] num,
  output logic [3:0] oh,
  output logic       last
);

  assign oh   = mask & (~mask + 4'd1);
  assign last = (mask != 4'd0) && ((mask & ~oh) == 4'd0);

  always_comb begin
    num = 3'd1;
    unique case (1'b1)
      oh[0]:   num = 3'd2;
      oh[1]:   num = 3'd3;
      oh[2]:   num = 3'd4;
      oh[3]:   num = 3'd5;
      default: num = 3'd1;
    endcase
  end

endmodule

// File: rtl/cyc_ctrl.sv
// cyc_ctrl: machine-cycle / T-state sequencer with registered bus strobes.
// Define CYC_CTRL_WAIT_EN to insert TW wait states while ready is low.
module cyc_ctrl
  import cyc_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [INSTSIZE-1:0] chk_i,
  input  logic                ready,
  output logic [IENBSIZE-1:0] ienb,
  output logic                ale,
  output logic                rd_,
  output logic                wr_,
  output logic                io_m,
  output logic                halt,
  output logic [2:0]          mcyc,
  output logic [2:0]          tst
);

  tstate_t state, nstate;
  logic    run;
  logic [3:0] pend, npend, wr_q, cd_q;
  logic dio_q, hlt_q, last_q, nlast;
  logic [2:0] nmcyc;
  logic [IENBSIZE-1:0] n_ienb;
  logic n_ale, n_rd, n_wr, n_iom, n_halt;
  logic go_next, drv2, drv3, wait_req;
  logic unused_ok;

`ifdef CYC_CTRL_WAIT_EN
  assign wait_req  = !ready;
  assign unused_ok = ^{chk_i[CK_COND], chk_i[1]};
`else
  assign wait_req  = 1'b0;
  assign unused_ok = ^{chk_i[CK_COND], chk_i[1], ready};
`endif

  // T4 exit latches chk_i, so decisions there use the live fields
  logic is_t4;
  logic [3:0] pend_s, cd_s;
  logic hlt_s, dio_s;
  assign is_t4  = (state == S_T4);
  assign pend_s = is_t4 ? chk_i[CK_EX +: 4] : pend;
  assign cd_s   = is_t4 ? chk_i[CK_CD +: 4] : cd_q;
  assign hlt_s  = is_t4 ? chk_i[CK_HLT] : hlt_q;
  assign dio_s  = is_t4 ? chk_i[CK_DIO] : dio_q;

  logic [2:0] pk_num;
  logic [3:0] pk_oh;
  logic pk_last;

  cyc_pick u_pick (
    .mask (pend_s),
    .num  (pk_num),
    .oh   (pk_oh),
    .last (pk_last)
  );

  logic m1, cur_wr, cur_cd, cur_io;
  assign m1     = (mcyc == 3'd1);
  assign cur_wr = |(wr_q & cyc_bit(mcyc));
  assign cur_cd = |(cd_q & cyc_bit(mcyc));
  assign cur_io = (mcyc == 3'd3) && dio_q;
  assign tst    = state;

  always_comb begin
    nstate  = state;
    nmcyc   = mcyc;
    npend   = pend_s;
    nlast   = last_q;
    n_ienb  = '0;
    n_ale   = 1'b0;
    n_rd    = 1'b1;
    n_wr    = 1'b1;
    n_iom   = 1'b0;
    n_halt  = 1'b0;
    go_next = 1'b0;
    drv2    = 1'b0;
    drv3    = 1'b0;
    if (!run) begin
      nstate = S_T1;
      nmcyc  = 3'd1;
      n_ale  = 1'b1;
    end else begin
      unique case (state)
        S_T1: begin
          nstate = S_T2;
          drv2   = 1'b1;
        end
        S_T2, S_TW: begin
          if (wait_req) begin
            nstate = S_TW;
            drv2   = 1'b1;
          end else begin
            nstate = S_T3;
            drv3   = 1'b1;
          end
        end
        S_T3: begin
          if (m1) begin
            nstate = S_T4;
            n_ienb[EN_RRD] = 1'b1;
            n_ienb[EN_RWR] = (chk_i[CK_EX +: 4] == 4'd0)
                             && !chk_i[CK_HLT];
          end else begin
            go_next = 1'b1;
          end
        end
        S_T4: begin
          if (chk_i[CK_GO6]) nstate = S_T5;
          else go_next = 1'b1;
        end
        S_T5:    nstate = S_T6;
        S_T6:    go_next = 1'b1;
        S_HALT:  n_halt = 1'b1;
        default: nstate = S_T1;
      endcase

      if (drv2) begin
        if (m1) begin
          n_rd = 1'b0;
        end else begin
          n_ienb[EN_PD] = cur_cd;
          n_iom = cur_io;
          if (cur_wr) begin
            n_wr = 1'b0;
            n_ienb[EN_RRD] = 1'b1;
          end else begin
            n_rd = 1'b0;
          end
        end
      end

      if (drv3) begin
        if (m1) begin
          n_rd = 1'b0;
          n_ienb[EN_COD] = 1'b1;
          n_ienb[EN_PC]  = 1'b1;
        end else begin
          n_ienb[EN_PD] = cur_cd;
          n_iom = cur_io;
          if (cur_wr) begin
            n_wr = 1'b0;
            n_ienb[EN_RRD] = 1'b1;
          end else begin
            n_rd = 1'b0;
            n_ienb[EN_DAT] = 1'b1;
            n_ienb[EN_PC]  = !cur_cd;
            n_ienb[EN_RWR] = last_q;
          end
        end
      end

      if (go_next) begin
        if (pend_s == 4'd0) begin
          if (hlt_s) begin
            nstate = S_HALT;
            n_halt = 1'b1;
          end else begin
            nstate = S_T1;
            nmcyc  = 3'd1;
            n_ale  = 1'b1;
          end
        end else begin
          nstate = S_T1;
          nmcyc  = pk_num;
          n_ale  = 1'b1;
          npend  = pend_s & ~pk_oh;
          nlast  = pk_last;
          n_ienb[EN_PD] = |(cd_s & pk_oh);
          n_iom = (pk_num == 3'd3) && dio_s;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_T1;
      mcyc   <= 3'd1;
      run    <= 1'b0;
      pend   <= '0;
      last_q <= 1'b0;
      wr_q   <= '0;
      cd_q   <= '0;
      dio_q  <= 1'b0;
      hlt_q  <= 1'b0;
      ienb   <= '0;
      ale    <= 1'b0;
      rd_    <= 1'b1;
      wr_    <= 1'b1;
      io_m   <= 1'b0;
      halt   <= 1'b0;
    end else begin
      state  <= nstate;
      mcyc   <= nmcyc;
      run    <= 1'b1;
      pend   <= npend;
      last_q <= nlast;
      ienb   <= n_ienb;
      ale    <= n_ale;
      rd_    <= n_rd;
      wr_    <= n_wr;
      io_m   <= n_iom;
      halt   <= n_halt;
      if (is_t4) begin
        wr_q  <= chk_i[CK_WR +: 4];
        cd_q  <= chk_i[CK_CD +: 4];
        dio_q <= chk_i[CK_DIO];
        hlt_q <= chk_i[CK_HLT];
      end
    end
  end

endmodule

// File: tb/tb_cyc_ctrl.sv
// tb_cyc_ctrl: builds the expected per-clock bus trace of each
// instruction from its chk_i word and compares the DUT against it.
module tb_cyc_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [16:0] chk_i = '0;
  logic        ready = 1'b1;
  logic [5:0]  ienb;
  logic        ale, rd_, wr_, io_m, halt;
  logic [2:0]  mcyc, tst;

  int total = 0;
  int bad = 0;

`ifdef CYC_CTRL_WAIT_EN
  localparam bit WAITS = 1'b1;
`else
  localparam bit WAITS = 1'b0;
`endif

  cyc_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .chk_i (chk_i),
    .ready (ready),
    .ienb  (ienb),
    .ale   (ale),
    .rd_   (rd_),
    .wr_   (wr_),
    .io_m  (io_m),
    .halt  (halt),
    .mcyc  (mcyc),
    .tst   (tst)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] tst;
    logic [2:0] mcyc;
    logic [5:0] ienb;
    logic ale, rd, wr, io, halt;
  } obs_t;

  obs_t q[$];
  bit   rq[$];

  function automatic obs_t mk(input int t, input int mc,
    input logic [5:0] en, input bit a, input bit r,
    input bit w, input bit io, input bit h);
    obs_t o;
    o.tst = 3'(t);
    o.mcyc = 3'(mc);
    o.ienb = en;
    o.ale = a;
    o.rd = r;
    o.wr = w;
    o.io = io;
    o.halt = h;
    return o;
  endfunction

  function automatic obs_t seen();
    return {tst, mcyc, ienb, ale, rd_, wr_, io_m, halt};
  endfunction

  function automatic bit rnd();
    return 1'($urandom);
  endfunction

  task automatic check(input string tag, input obs_t o,
    input obs_t e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, o, e);
    end
  endtask

  // One bus cycle's T2, TW* and T3 entries; bit order of ienb is
  // PD_ PC_ DAT COD RWR RRD.
  task automatic add_cyc(input int n, input bit iswr,
    input bit pd, input bit io, input bit last, input int w);
    obs_t t2, t3, tw;
    logic [5:0] pdv;
    int ww;
    pdv = pd ? 6'b100000 : 6'b000000;
    ww = WAITS ? w : 0;
    if (n == 1) begin
      t2 = mk(2, 1, 6'b0, 0, 0, 1, 0, 0);
      t3 = mk(3, 1, 6'b010100, 0, 0, 1, 0, 0);
    end else if (iswr) begin
      t2 = mk(2, n, pdv | 6'b000001, 0, 1, 0, io, 0);
      t3 = mk(3, n, pdv | 6'b000001, 0, 1, 0, io, 0);
    end else begin
      t2 = mk(2, n, pdv, 0, 0, 1, io, 0);
      t3 = mk(3, n, pdv | 6'b001000
                    | (pd ? 6'b0 : 6'b010000)
                    | (last ? 6'b000010 : 6'b0),
              0, 0, 1, io, 0);
    end
    q.push_back(t2);
    rq.push_back(WAITS ? (ww == 0) : rnd());
    for (int i = 0; i < ww; i++) begin
      tw = t2;
      tw.tst = 3'd7;
      q.push_back(tw);
      rq.push_back(i == ww - 1);
    end
    q.push_back(t3);
    rq.push_back(rnd());
  endtask

  task automatic build(input logic [16:0] c, input int w1,
    input int w4);
    bit go6, hlt, dio, last;
    logic [3:0] ex, wrm, cd, hi;
    int n, last_n, w;
    go6 = c[0];
    hlt = c[2];
    dio = c[3];
    ex = c[7:4];
    wrm = c[11:8];
    cd = c[15:12];
    last_n = 1;
    q.delete();
    rq.delete();
    q.push_back(mk(1, 1, 6'b0, 1, 1, 1, 0, 0));
    rq.push_back(rnd());
    add_cyc(1, 0, 0, 0, 0,
            w1 >= 0 ? w1 : int'($urandom_range(0, 2)));
    q.push_back(mk(4, 1,
      (ex == 4'd0 && !hlt) ? 6'b000011 : 6'b000001,
      0, 1, 1, 0, 0));
    rq.push_back(rnd());
    if (go6) begin
      q.push_back(mk(5, 1, 6'b0, 0, 1, 1, 0, 0));
      rq.push_back(rnd());
      q.push_back(mk(6, 1, 6'b0, 0, 1, 1, 0, 0));
      rq.push_back(rnd());
    end
    for (int k = 0; k < 4; k++) begin
      if (ex[k]) begin
        n = k + 2;
        hi = ex >> (k + 1);
        last = (hi == 4'd0);
        q.push_back(mk(1, n, cd[k] ? 6'b100000 : 6'b0, 1, 1, 1,
                       (n == 3) && dio, 0));
        rq.push_back(rnd());
        w = (n == 4 && w4 >= 0) ? w4 : int'($urandom_range(0, 2));
        add_cyc(n, wrm[k], cd[k], (n == 3) && dio, last, w);
        last_n = n;
      end
    end
    if (hlt) begin
      for (int i = 0; i < 20; i++) begin
        q.push_back(mk(0, last_n, 6'b0, 0, 1, 1, 0, 1));
        rq.push_back(rnd());
      end
    end
  endtask

  task automatic run(input logic [16:0] c, input string tag,
    input int stop);
    int n;
    n = (stop < 0) ? q.size() : stop;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0) chk_i = c;
      ready = rq[i];
      check($sformatf("%s[%0d]", tag, i), seen(), q[i]);
    end
  endtask

  task automatic pulse_rst(input string tag);
    rst = 1'b1;
    @(negedge clk);
    check(tag, seen(), mk(1, 1, 6'b0, 0, 1, 1, 0, 0));
    rst = 1'b0;
  endtask

  initial begin
    logic [16:0] c;
    int idx;

    pulse_rst("reset");

    c = 17'h00000;
    build(c, -1, -1);
    run(c, "mov_rr", -1);

    c = 17'h00001;
    build(c, -1, -1);
    run(c, "inx", -1);

    c = 17'h01110;
    build(c, -1, -1);
    run(c, "mov_mr", -1);

    c = 17'h00000;
    build(c, 3, -1);
    run(c, "wait_m1", -1);

    for (int j = 0; j < 30; j++) begin
      c = 17'($urandom);
      c[2] = 1'b0;
      build(c, -1, -1);
      run(c, $sformatf("rnd%0d", j), -1);
    end

    c = 17'h0F0F0;
    build(c, -1, -1);
    run(c, "mask_f", -1);

    c = 17'h00014;
    build(c, -1, -1);
    run(c, "hlt", -1);
    pulse_rst("hlt_rst");

    c = 17'h00004;
    build(c, -1, -1);
    run(c, "hlt_m1", -1);
    pulse_rst("hlt_m1_rst");

    c = 17'h0A5F8;
    build(c, -1, 2);
    idx = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (idx == 0 && q[i].mcyc == 3'd4
          && q[i].tst == (WAITS ? 3'd7 : 3'd2))
        idx = i;
    end
    run(c, "mid", idx + 1);
    pulse_rst("mid_rst");

    c = 17'h00000;
    build(c, -1, -1);
    run(c, "after", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
